// File: rtl/dbuffer_sram_be.sv
// dbuffer_sram_be: single-port synchronous data-buffer SRAM for the MEM stage.
// Per-byte write enables, registered one-cycle read with a valid strobe, a
// hardware clear engine that zeroes the array after reset or on request, and
// out-of-range access detection.
//
// Optional feature: define DBUFFER_BYPASS_EN for write-first behaviour on a
// same-cycle read+write (merged word returned); otherwise read-first.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   buffer_csn        chip select, active low
//   buffer_addr       word address
//   buffer_write_en   write request
//   buffer_read_en    read request
//   buffer_be         byte enables for writes (bit i -> bits [8i+7:8i])
//   buffer_datain     write data
//   buffer_clr        one-cycle pulse requesting a full array clear
//   buffer_dataout    registered read data (holds between reads)
//   buffer_rvalid     one-cycle pulse marking new buffer_dataout
//   buffer_ready      high when accesses are accepted
//   buffer_err        one-cycle pulse on an accepted access with addr >= DEPTH
module dbuffer_sram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      buffer_csn,
    input  logic [ADDR_WIDTH-1:0]     buffer_addr,
    input  logic                      buffer_write_en,
    input  logic                      buffer_read_en,
    input  logic [DATA_WIDTH/8-1:0]   buffer_be,
    input  logic [DATA_WIDTH-1:0]     buffer_datain,
    input  logic                      buffer_clr,
    output logic [DATA_WIDTH-1:0]     buffer_dataout,
    output logic                      buffer_rvalid,
    output logic                      buffer_ready,
    output logic                      buffer_err
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_range_c;
    logic                    accept_c;
    logic                    rd_acc_c;
    logic [IDX_W-1:0]        acc_idx_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;

    logic                    mem_we_c;
    logic [NB-1:0]           mem_be_c;
    logic [IDX_W-1:0]        mem_idx_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;

    logic                    ready_nxt;
    logic                    rvalid_nxt;
    logic                    err_nxt;
    logic [DATA_WIDTH-1:0]   dout_nxt;

    // State register and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic; a clear request while already clearing is ignored
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = ST_READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (buffer_clr) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Output / datapath decode: access acceptance, array write port, next outputs
    always_comb begin
        in_range_c  = ({1'b0, buffer_addr} < CMP_W'(DEPTH));
        // a clear request drops any access presented in the same cycle
        accept_c    = (state == ST_READY) && !buffer_csn &&
                      (buffer_read_en || buffer_write_en) && !buffer_clr;
        rd_acc_c    = accept_c && buffer_read_en;
        acc_idx_c   = IDX_W'(buffer_addr);

        // out-of-range reads return zero and never touch the array
        rd_word_c   = in_range_c ? mem[acc_idx_c] : '0;
        rd_data_c   = rd_word_c;
`ifdef DBUFFER_BYPASS_EN
        // write-first: enabled bytes of a same-cycle write override old contents
        for (int i = 0; i < NB; i++) begin
            if (in_range_c && buffer_write_en && buffer_be[i]) begin
                rd_data_c[8*i +: 8] = buffer_datain[8*i +: 8];
            end
        end
`endif

        mem_we_c    = 1'b0;
        mem_be_c    = '0;
        mem_idx_c   = acc_idx_c;
        mem_wdata_c = '0;
        if (state == ST_CLEAR) begin
            mem_we_c  = 1'b1;
            mem_be_c  = '1;
            mem_idx_c = IDX_W'(clr_cnt);
        end else if (accept_c && buffer_write_en && in_range_c) begin
            mem_we_c    = 1'b1;
            mem_be_c    = buffer_be;
            mem_wdata_c = buffer_datain;
        end

        ready_nxt  = (state_nxt == ST_READY);
        rvalid_nxt = rd_acc_c;
        err_nxt    = accept_c && !in_range_c;
        dout_nxt   = buffer_dataout;
        if (rd_acc_c) begin
            dout_nxt = in_range_c ? rd_data_c : '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer_ready   <= 1'b0;
            buffer_rvalid  <= 1'b0;
            buffer_err     <= 1'b0;
            buffer_dataout <= '0;
        end else begin
            buffer_ready   <= ready_nxt;
            buffer_rvalid  <= rvalid_nxt;
            buffer_err     <= err_nxt;
            buffer_dataout <= dout_nxt;
        end
    end

    // Storage array with per-byte write; contents are zeroed only by the clear engine
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_idx_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dbuffer_sram_be.md
# dbuffer_sram_be

Parametrised data-buffer SRAM for the MEM stage: single-port, synchronous, with per-byte write enables for sub-word RISC-V stores, a registered one-cycle read with a valid strobe, and a hardware clear engine that zeroes the array after reset or on request. It replaces the fixed 32-bit word-only data buffer between the load/store unit and the data path. It also adds out-of-range detection and optional same-cycle write-to-read forwarding.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word-address width.
- DEPTH, 1024, number of words; DEPTH ≤ 2^ADDR_WIDTH and need not be a power of two.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- buffer_csn  input  1  chip select, active low.
- buffer_addr  input  ADDR_WIDTH  word address.
- buffer_write_en  input  1  write request.
- buffer_read_en  input  1  read request.
- buffer_be  input  DATA_WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
- buffer_datain  input  DATA_WIDTH  write data.
- buffer_clr  input  1  one-cycle pulse that requests a full array clear.
- buffer_dataout  output  DATA_WIDTH  registered read data.
- buffer_rvalid  output  1  one-cycle pulse marking new buffer_dataout.
- buffer_ready  output  1  high when accesses are accepted.
- buffer_err  output  1  one-cycle pulse on an access with buffer_addr ≥ DEPTH.

## Operation
- The FSM has two states:
  - CLEAR: writes zero to word clr_cnt each cycle, where clr_cnt counts from 0 to DEPTH-1. After the write to DEPTH-1 it moves to READY.
  - READY: serves accesses.
- buffer_clr in READY moves the FSM to CLEAR with clr_cnt=0. Any access in that same cycle is dropped. buffer_clr in CLEAR is ignored; the clear does not restart.
- An access is accepted when buffer_ready=1, ~buffer_csn, (read_en|write_en), and buffer_clr=0.
- Accepted write, addr < DEPTH: for each i with buffer_be[i]=1, update byte i of Memory[addr]. Other bytes are unchanged. be=0 is a legal no-op write.
- Accepted read, addr < DEPTH: buffer_dataout ← Memory[addr] and buffer_rvalid=1 on the next edge.
- Accepted access with addr ≥ DEPTH:
  - No array change.
  - buffer_err=1 next cycle.
  - A read also loads buffer_dataout=0 and pulses buffer_rvalid.
- Read and write to the same address in the same cycle: see Configuration.
- Accesses while buffer_ready=0 are silently ignored. They produce no rvalid and no err.
- buffer_dataout holds its last value between reads.

## Timing
- Reset values: state=CLEAR, clr_cnt=0, buffer_ready=0, buffer_rvalid=0, buffer_err=0, buffer_dataout=0.
- Memory contents are not reset directly; the clear engine zeroes them.
- Clear duration is exactly DEPTH cycles.
  - buffer_ready rises on the edge after the clear write to DEPTH-1.
  - After rst_n deasserts, buffer_ready is first high in cycle DEPTH.
- Read latency is 1 cycle: request at edge N gives dataout/rvalid valid after edge N+1. Back-to-back reads give rvalid high every cycle.
- Write latency: data is visible to a read issued on the next cycle.
- buffer_ready falls on the edge that samples buffer_clr=1.
- Reset asserted mid-clear or mid-access:
  - Immediate return to reset values and CLEAR.
  - The in-flight write may or may not complete.
  - The clear restarts from 0.
- rvalid and err are pulses; they are never held across two cycles for one access.

## Configuration
- DBUFFER_BYPASS_EN defined: for a same-cycle read+write to the same in-range address, buffer_dataout returns the merged word. Enabled bytes come from buffer_datain; the remaining bytes come from the old contents (write-first).
- DBUFFER_BYPASS_EN undefined: buffer_dataout returns the old contents (read-first). The array still receives the write.

## Test plan
All scenarios use DATA_WIDTH=32, ADDR_WIDTH=5, DEPTH=20.
- Reset/clear:
  - Stimulus: deassert rst_n, drive reads every cycle from cycle 0.
  - Required: no rvalid and ready=0 for cycles 0–19.
  - Required: ready=1 at cycle 20; a read of addr 7 returns 0x00000000 with rvalid one cycle later.
- Byte enables:
  - Stimulus: write 0xAABBCCDD be=4'b1111 to addr 3, then 0x11223344 be=4'b0101 to addr 3, then read addr 3.
  - Required: dataout=0xAA22CC44, rvalid one pulse.
- Same-cycle read+write:
  - Stimulus: addr 5 holds 0x0; issue read and write 0xFFFFFFFF be=4'b0011 together.
  - Required: dataout=0x0000FFFF with DBUFFER_BYPASS_EN, 0x00000000 without.
  - Required: a follow-up read returns 0x0000FFFF in both builds.
- Out of range:
  - Stimulus: write 0x12345678 to addr 25, then read addr 25.
  - Required: err pulses after each access; read gives dataout=0 with rvalid.
  - Required: a full scan of addrs 0–19 is unchanged.
- Clear request:
  - Stimulus: fill addr 0–19 with 0xDEADBEEF; pulse buffer_clr together with a write to addr 2.
  - Required: ready low for exactly 20 cycles; the write is dropped; all addrs read 0.
  - Required: a second buffer_clr mid-clear does not extend the 20 cycles.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 at clear cycle 10, release after 2 cycles.
  - Required: ready reasserts exactly 20 cycles after release.
